snax_cgra_tcdm_bridge: RTL and testbench
========================================

SNAX_CGRA_TCDM_BRIDGE -- requirements
Module: snax_cgra_tcdm_bridge

Interface
REQ-001 SHALL have parameter NumChannels, default 4: number of CGRA memory channels bridged to TCDM ports.
REQ-002 SHALL have parameter CgraAddrWidth, default 6: CGRA word-address width.
REQ-003 SHALL have parameter TCDMAddrWidth, default 48: TCDM byte-address width.
REQ-004 SHALL have parameter DataWidth, default 64: TCDM data width, a power of 2 and at least 8.
REQ-005 SHALL have parameter PayloadWidth, default 16: CGRA payload width, at most DataWidth.
REQ-006 SHALL have parameter RspDepth, default 2: per-channel response FIFO depth and read credit limit, at least 1.
REQ-007 Ports, grouped in order, each as name direction width meaning:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- base_addr_i  in  TCDMAddrWidth  byte base added to all addresses.
- waddr_en_i / waddr_msg_i  in  NumChannels / NumChannels*CgraAddrWidth  CGRA write address.
- wdata_en_i / wdata_msg_i  in  NumChannels / NumChannels*(PayloadWidth+2)  CGRA write data {payload,predicate,bypass}.
- w_rdy_o  out  NumChannels  write accepted (shared by waddr/wdata).
- raddr_en_i / raddr_msg_i  in  NumChannels / NumChannels*CgraAddrWidth  CGRA read address.
- raddr_rdy_o  out  NumChannels  read address accepted.
- rdata_en_o / rdata_msg_o  out  NumChannels / NumChannels*(PayloadWidth+2)  read data to CGRA.
- rdata_rdy_i  in  NumChannels  CGRA accepts read data.
- tcdm_q_valid_o, tcdm_q_write_o  out  NumChannels each  TCDM request valid and write flag.
- tcdm_q_addr_o  out  NumChannels*TCDMAddrWidth  TCDM request address.
- tcdm_q_data_o  out  NumChannels*DataWidth  TCDM write data.
- tcdm_q_strb_o  out  NumChannels*DataWidth/8  TCDM byte strobes.
- tcdm_q_ready_i, tcdm_p_valid_i  in  NumChannels each  TCDM request ready and response valid; the response has no ready.
- tcdm_p_data_i  in  NumChannels*DataWidth  TCDM response data.
- busy_o  out  1  activity flag.
- perf_stall_o  out  NumChannels*32  per-channel stall counters.

Function
REQ-008 Channels SHALL be fully independent.
REQ-009 Each channel SHALL hold a one-entry request register that loads on CGRA acceptance.
REQ-010 The request register SHALL be free when empty, or when tcdm_q_valid_o and tcdm_q_ready_i are both high in the same cycle.
REQ-011 w_rdy_o SHALL be high when the register is free and waddr_en_i and wdata_en_i are both high.
REQ-012 raddr_rdy_o SHALL be high when the register is free, no write is being accepted, and outstanding reads plus FIFO occupancy is below RspDepth.
REQ-013 If write and read are requested in the same cycle, the write SHALL win and the read SHALL stall.
REQ-014 A write whose predicate is 0 SHALL be consumed (w_rdy_o high) and SHALL issue no TCDM request.
REQ-015 Latency: a CGRA request accepted in cycle N SHALL drive tcdm_q_valid_o in cycle N+1, held stable until tcdm_q_ready_i is sampled high.
REQ-016 Address SHALL be base_addr_i + (addr_msg << log2(DataWidth/8)), truncated to TCDMAddrWidth; base_addr_i is sampled at acceptance.
REQ-017 Write data SHALL be the payload zero-extended to DataWidth; strobes SHALL be all ones; read requests SHALL drive zero data and zero strobes.
REQ-018 Each channel SHALL keep an outstanding-read counter: +1 on a read handshake, -1 on tcdm_p_valid_i, unchanged when both occur.
REQ-019 tcdm_p_valid_i SHALL push {p_data[PayloadWidth-1:0],1,0} into the channel FIFO.
REQ-020 tcdm_p_valid_i while the counter is 0 SHALL be dropped.
REQ-021 rdata_en_o SHALL equal FIFO not-empty; the FIFO SHALL pop when rdata_en_o and rdata_rdy_i are both high.
REQ-022 Response latency SHALL be exactly 1 cycle from tcdm_p_valid_i to rdata_en_o when the FIFO is empty.
REQ-023 Push and pop in the same cycle SHALL be allowed at any occupancy; the credit rule SHALL guarantee the FIFO never overflows.
REQ-024 FIFO pointers SHALL wrap modulo RspDepth, including non-power-of-2 depths.
REQ-025 busy_o SHALL be high when any request register is full, any counter is non-zero, or any FIFO is non-empty.

Reset
REQ-026 While rst_i is high at a clock edge, all request registers, counters and FIFOs SHALL clear.
REQ-027 During and after reset, tcdm_q_valid_o, rdata_en_o, busy_o, w_rdy_o, raddr_rdy_o and perf_stall_o SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon pending requests; late responses SHALL be dropped per REQ-020.

Configuration
REQ-029 With SNAX_CGRA_BRIDGE_PERF_EN defined, each channel SHALL count cycles with tcdm_q_valid_o high and tcdm_q_ready_i low, 32-bit saturating, cleared by reset, on perf_stall_o.
REQ-030 Without SNAX_CGRA_BRIDGE_PERF_EN, perf_stall_o SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-031 base=0x1000, ch0 write addr 3, payload 0xBEEF, pred 1, q_ready=1 -> next cycle q_valid=1, write=1, addr=0x1018, data=0xBEEF, strb=0xFF.
REQ-032 ch1 write and read in the same cycle -> w_rdy_o=1, raddr_rdy_o=0; the read is issued the following cycle.
REQ-033 RspDepth=2, ch2 three back-to-back reads with p_valid withheld and rdata_rdy=0 -> the third read stalls until one response is popped.
REQ-034 ch0 q_ready=0 for 5 cycles with PERF_EN -> perf_stall_o[ch0]=5; same test without PERF_EN -> 0.
REQ-035 ch3 write with predicate 0 -> w_rdy_o=1 and no tcdm_q_valid_o.
REQ-036 rst_i asserted with 1 read outstanding, then p_valid -> rdata_en_o stays 0 and busy_o=0.

Source files
------------

// File: rtl/snax_cgra_tcdm_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : snax_cgra_tcdm_bridge_if
// Brief    : CGRA-side and TCDM-side signal bundle of the CGRA/TCDM bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface snax_cgra_tcdm_bridge_if #(
  parameter int NumChannels   = 4,
  parameter int CgraAddrWidth = 6,
  parameter int TCDMAddrWidth = 48,
  parameter int DataWidth     = 64,
  parameter int PayloadWidth  = 16
);
  logic [TCDMAddrWidth-1:0]                base_addr_i;
  logic [NumChannels-1:0]                  waddr_en_i;
  logic [NumChannels*CgraAddrWidth-1:0]    waddr_msg_i;
  logic [NumChannels-1:0]                  wdata_en_i;
  logic [NumChannels*(PayloadWidth+2)-1:0] wdata_msg_i;
  logic [NumChannels-1:0]                  w_rdy_o;
  logic [NumChannels-1:0]                  raddr_en_i;
  logic [NumChannels*CgraAddrWidth-1:0]    raddr_msg_i;
  logic [NumChannels-1:0]                  raddr_rdy_o;
  logic [NumChannels-1:0]                  rdata_en_o;
  logic [NumChannels*(PayloadWidth+2)-1:0] rdata_msg_o;
  logic [NumChannels-1:0]                  rdata_rdy_i;
  logic [NumChannels-1:0]                  tcdm_q_valid_o;
  logic [NumChannels-1:0]                  tcdm_q_write_o;
  logic [NumChannels*TCDMAddrWidth-1:0]    tcdm_q_addr_o;
  logic [NumChannels*DataWidth-1:0]        tcdm_q_data_o;
  logic [NumChannels*DataWidth/8-1:0]      tcdm_q_strb_o;
  logic [NumChannels-1:0]                  tcdm_q_ready_i;
  logic [NumChannels-1:0]                  tcdm_p_valid_i;
  logic [NumChannels*DataWidth-1:0]        tcdm_p_data_i;
  logic                                    busy_o;
  logic [NumChannels*32-1:0]               perf_stall_o;

  modport slave (
    input  base_addr_i, waddr_en_i, waddr_msg_i, wdata_en_i, wdata_msg_i,
    input  raddr_en_i, raddr_msg_i, rdata_rdy_i,
    input  tcdm_q_ready_i, tcdm_p_valid_i, tcdm_p_data_i,
    output w_rdy_o, raddr_rdy_o, rdata_en_o, rdata_msg_o,
    output tcdm_q_valid_o, tcdm_q_write_o, tcdm_q_addr_o, tcdm_q_data_o, tcdm_q_strb_o,
    output busy_o, perf_stall_o
  );

  modport master (
    output base_addr_i, waddr_en_i, waddr_msg_i, wdata_en_i, wdata_msg_i,
    output raddr_en_i, raddr_msg_i, rdata_rdy_i,
    output tcdm_q_ready_i, tcdm_p_valid_i, tcdm_p_data_i,
    input  w_rdy_o, raddr_rdy_o, rdata_en_o, rdata_msg_o,
    input  tcdm_q_valid_o, tcdm_q_write_o, tcdm_q_addr_o, tcdm_q_data_o, tcdm_q_strb_o,
    input  busy_o, perf_stall_o
  );
endinterface
`default_nettype wire

// File: rtl/snax_cgra_tcdm_bridge.sv
`default_nettype none
// ============================================================================
// Module   : snax_cgra_tcdm_bridge
// Brief    : Per-channel bridge from CGRA memory ports to TCDM request/response
//            ports; optional stall counters via SNAX_CGRA_BRIDGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module snax_cgra_tcdm_bridge #(
  parameter int NumChannels   = 4,
  parameter int CgraAddrWidth = 6,
  parameter int TCDMAddrWidth = 48,
  parameter int DataWidth     = 64,
  parameter int PayloadWidth  = 16,
  parameter int RspDepth      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  snax_cgra_tcdm_bridge_if.slave bus
);
  localparam int MsgWidth  = PayloadWidth + 2;
  localparam int StrbWidth = DataWidth / 8;
  localparam int ByteOffs  = $clog2(DataWidth / 8);
  localparam int CntWidth  = $clog2(RspDepth + 1);
  localparam int PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  logic [NumChannels-1:0] ch_busy;

  function automatic logic [TCDMAddrWidth-1:0] tcdm_addr(
    input logic [TCDMAddrWidth-1:0] base,
    input logic [CgraAddrWidth-1:0] word_addr
  );
    logic [TCDMAddrWidth-1:0] ext;
    ext = TCDMAddrWidth'(word_addr);
    return base + (ext << ByteOffs);
  endfunction

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(RspDepth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ch
    logic                     req_full;
    logic                     req_write;
    logic [TCDMAddrWidth-1:0] req_addr;
    logic [PayloadWidth-1:0]  req_payload;
    logic [CntWidth-1:0]      outstanding;
    logic [CntWidth-1:0]      fifo_cnt;
    logic [PtrWidth-1:0]      wr_ptr;
    logic [PtrWidth-1:0]      rd_ptr;
    logic [MsgWidth-1:0]      fifo_mem [RspDepth];
    logic [CntWidth:0]        in_flight;
    logic [CgraAddrWidth-1:0] waddr;
    logic [CgraAddrWidth-1:0] raddr;
    logic [MsgWidth-1:0]      wmsg;
    logic [DataWidth-1:0]     pdata;
    logic                     w_req, free, q_hs, credit_ok;
    logic                     w_acc, r_acc, push, pop;
    logic                     unused_bits;

    assign waddr = bus.waddr_msg_i[ch*CgraAddrWidth +: CgraAddrWidth];
    assign raddr = bus.raddr_msg_i[ch*CgraAddrWidth +: CgraAddrWidth];
    assign wmsg  = bus.wdata_msg_i[ch*MsgWidth +: MsgWidth];
    assign pdata = bus.tcdm_p_data_i[ch*DataWidth +: DataWidth];
    assign unused_bits = ^{pdata, wmsg[0]};

    // Reads are credited from CGRA acceptance, so a read parked in the
    // request register already reserves its FIFO slot.
    assign in_flight = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign credit_ok = in_flight < (CntWidth+1)'(RspDepth);

    assign q_hs  = req_full && bus.tcdm_q_ready_i[ch];
    assign free  = !req_full || q_hs;
    assign w_req = bus.waddr_en_i[ch] && bus.wdata_en_i[ch];
    assign w_acc = !rst_i && free && w_req;
    assign r_acc = !rst_i && free && !w_acc && credit_ok && bus.raddr_en_i[ch];
    assign push  = bus.tcdm_p_valid_i[ch] && (outstanding != '0);
    assign pop   = (fifo_cnt != '0) && bus.rdata_rdy_i[ch];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        req_full    <= 1'b0;
        req_write   <= 1'b0;
        req_addr    <= '0;
        req_payload <= '0;
      end else if (w_acc && wmsg[1]) begin
        req_full    <= 1'b1;
        req_write   <= 1'b1;
        req_addr    <= tcdm_addr(bus.base_addr_i, waddr);
        req_payload <= wmsg[MsgWidth-1:2];
      end else if (r_acc) begin
        req_full    <= 1'b1;
        req_write   <= 1'b0;
        req_addr    <= tcdm_addr(bus.base_addr_i, raddr);
        req_payload <= '0;
      end else if (q_hs) begin
        req_full    <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        outstanding <= '0;
        fifo_cnt    <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (r_acc && !push)      outstanding <= outstanding + CntWidth'(1);
        else if (push && !r_acc) outstanding <= outstanding - CntWidth'(1);
        if (push && !pop)        fifo_cnt <= fifo_cnt + CntWidth'(1);
        else if (pop && !push)   fifo_cnt <= fifo_cnt - CntWidth'(1);
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= {pdata[PayloadWidth-1:0], 1'b1, 1'b0};
    end

    assign bus.w_rdy_o[ch]        = w_acc;
    assign bus.raddr_rdy_o[ch]    = r_acc;
    assign bus.rdata_en_o[ch]     = (fifo_cnt != '0);
    assign bus.rdata_msg_o[ch*MsgWidth +: MsgWidth] = fifo_mem[rd_ptr];
    assign bus.tcdm_q_valid_o[ch] = req_full;
    assign bus.tcdm_q_write_o[ch] = req_write;
    assign bus.tcdm_q_addr_o[ch*TCDMAddrWidth +: TCDMAddrWidth] = req_addr;
    assign bus.tcdm_q_data_o[ch*DataWidth +: DataWidth]         = DataWidth'(req_payload);
    assign bus.tcdm_q_strb_o[ch*StrbWidth +: StrbWidth]         = {StrbWidth{req_write}};
    assign ch_busy[ch] = req_full || (outstanding != '0) || (fifo_cnt != '0);

`ifdef SNAX_CGRA_BRIDGE_PERF_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stall_cnt <= '0;
      end else if (req_full && !bus.tcdm_q_ready_i[ch] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
    assign bus.perf_stall_o[ch*32 +: 32] = stall_cnt;
`else
    assign bus.perf_stall_o[ch*32 +: 32] = '0;
`endif
  end

  assign bus.busy_o = |ch_busy;
endmodule
`default_nettype wire

// File: tb/tb_snax_cgra_tcdm_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_snax_cgra_tcdm_bridge
// Brief    : Directed scoreboard bench for snax_cgra_tcdm_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_cgra_tcdm_bridge;
  localparam int NC  = 4;
  localparam int CAW = 6;
  localparam int TAW = 48;
  localparam int DW  = 64;
  localparam int PW  = 16;
  localparam int RD  = 2;
  localparam int MW  = PW + 2;
`ifdef SNAX_CGRA_BRIDGE_PERF_EN
  localparam logic [63:0] EXP_STALL = 64'd5;
`else
  localparam logic [63:0] EXP_STALL = 64'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snax_cgra_tcdm_bridge_if #(
    .NumChannels(NC), .CgraAddrWidth(CAW), .TCDMAddrWidth(TAW),
    .DataWidth(DW), .PayloadWidth(PW)
  ) bus ();

  snax_cgra_tcdm_bridge #(
    .NumChannels(NC), .CgraAddrWidth(CAW), .TCDMAddrWidth(TAW),
    .DataWidth(DW), .PayloadWidth(PW), .RspDepth(RD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int               ch;
    logic             write;
    logic [TAW-1:0]   addr;
    logic [DW-1:0]    data;
    logic [DW/8-1:0]  strb;
  } req_t;
  typedef struct {
    int            ch;
    logic [MW-1:0] msg;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every TCDM request and every CGRA read response is matched
  // against the oldest expected entry of its channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        if (bus.tcdm_q_valid_o[c] && bus.tcdm_q_ready_i[c]) begin
          int idx;
          idx = -1;
          foreach (exp_req[i]) if (idx < 0 && exp_req[i].ch == c) idx = i;
          if (idx < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_req ch%0d: got addr 0x%0h, expected no request",
                     c, bus.tcdm_q_addr_o[c*TAW +: TAW]);
          end else begin
            chk($sformatf("req_write ch%0d", c), 64'(bus.tcdm_q_write_o[c]), 64'(exp_req[idx].write));
            chk($sformatf("req_addr ch%0d", c), 64'(bus.tcdm_q_addr_o[c*TAW +: TAW]), 64'(exp_req[idx].addr));
            chk($sformatf("req_data ch%0d", c), bus.tcdm_q_data_o[c*DW +: DW], exp_req[idx].data);
            chk($sformatf("req_strb ch%0d", c), 64'(bus.tcdm_q_strb_o[c*DW/8 +: DW/8]), 64'(exp_req[idx].strb));
            exp_req.delete(idx);
          end
        end
        if (bus.rdata_en_o[c] && bus.rdata_rdy_i[c]) begin
          int idx;
          idx = -1;
          foreach (exp_rsp[i]) if (idx < 0 && exp_rsp[i].ch == c) idx = i;
          if (idx < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp ch%0d: got msg 0x%0h, expected no response",
                     c, bus.rdata_msg_o[c*MW +: MW]);
          end else begin
            chk($sformatf("rsp_msg ch%0d", c), 64'(bus.rdata_msg_o[c*MW +: MW]), 64'(exp_rsp[idx].msg));
            exp_rsp.delete(idx);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int ch, input logic [CAW-1:0] a, input logic [PW-1:0] p, input logic pred);
    bus.waddr_en_i[ch] = 1'b1;
    bus.wdata_en_i[ch] = 1'b1;
    bus.waddr_msg_i[ch*CAW +: CAW] = a;
    bus.wdata_msg_i[ch*MW +: MW]   = {p, pred, 1'b0};
  endtask

  task automatic clr_w(input int ch);
    bus.waddr_en_i[ch] = 1'b0;
    bus.wdata_en_i[ch] = 1'b0;
  endtask

  task automatic set_r(input int ch, input logic [CAW-1:0] a);
    bus.raddr_en_i[ch] = 1'b1;
    bus.raddr_msg_i[ch*CAW +: CAW] = a;
  endtask

  task automatic clr_r(input int ch);
    bus.raddr_en_i[ch] = 1'b0;
  endtask

  task automatic exp_q(input int ch, input logic w, input logic [TAW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    req_t e;
    e.ch = ch; e.write = w; e.addr = a; e.data = d; e.strb = s;
    exp_req.push_back(e);
  endtask

  task automatic pvalid(input int ch, input logic [DW-1:0] d, input bit want, input logic [MW-1:0] msg);
    rsp_t e;
    if (want) begin
      e.ch = ch; e.msg = msg;
      exp_rsp.push_back(e);
    end
    bus.tcdm_p_valid_i[ch] = 1'b1;
    bus.tcdm_p_data_i[ch*DW +: DW] = d;
    cyc();
    bus.tcdm_p_valid_i[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.base_addr_i    = '0;
    bus.waddr_en_i     = '0;
    bus.waddr_msg_i    = '0;
    bus.wdata_en_i     = '0;
    bus.wdata_msg_i    = '0;
    bus.raddr_en_i     = '0;
    bus.raddr_msg_i    = '0;
    bus.rdata_rdy_i    = '1;
    bus.tcdm_q_ready_i = '1;
    bus.tcdm_p_valid_i = '0;
    bus.tcdm_p_data_i  = '0;

    // Reset: a write offered during reset must be neither accepted nor issued.
    set_w(0, 6'd3, 16'h5555, 1'b1);
    @(negedge clk);
    chk("rst_w_rdy", 64'(bus.w_rdy_o), 64'd0);
    chk("rst_raddr_rdy", 64'(bus.raddr_rdy_o), 64'd0);
    chk("rst_q_valid", 64'(bus.tcdm_q_valid_o), 64'd0);
    chk("rst_rdata_en", 64'(bus.rdata_en_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_perf", 64'(|bus.perf_stall_o), 64'd0);
    cyc();
    clr_w(0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_q_valid", 64'(bus.tcdm_q_valid_o), 64'd0);
    chk("post_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("post_rst_raddr_rdy", 64'(bus.raddr_rdy_o), 64'd0);

    // Basic write; base changes after acceptance and must not leak in.
    cyc();
    bus.base_addr_i = 48'h1000;
    set_w(0, 6'd3, 16'hBEEF, 1'b1);
    exp_q(0, 1'b1, 48'h1018, 64'hBEEF, 8'hFF);
    @(negedge clk);
    chk("t1_w_rdy", 64'(bus.w_rdy_o[0]), 64'd1);
    cyc();
    clr_w(0);
    bus.base_addr_i = 48'h2000;
    @(negedge clk);
    chk("t1_q_valid_next_cycle", 64'(bus.tcdm_q_valid_o[0]), 64'd1);

    // Write and read together on ch1: write wins, read follows.
    cyc();
    bus.base_addr_i = 48'h1000;
    set_w(1, 6'd5, 16'h1234, 1'b1);
    set_r(1, 6'd7);
    exp_q(1, 1'b1, 48'h1028, 64'h1234, 8'hFF);
    exp_q(1, 1'b0, 48'h1038, 64'h0, 8'h00);
    @(negedge clk);
    chk("t2_w_rdy", 64'(bus.w_rdy_o[1]), 64'd1);
    chk("t2_raddr_stall", 64'(bus.raddr_rdy_o[1]), 64'd0);
    cyc();
    clr_w(1);
    @(negedge clk);
    chk("t2_raddr_rdy_next", 64'(bus.raddr_rdy_o[1]), 64'd1);
    cyc();
    clr_r(1);
    @(negedge clk);
    chk("t2_read_issued", 64'({bus.tcdm_q_valid_o[1], bus.tcdm_q_write_o[1]}), 64'b10);
    cyc();
    pvalid(1, 64'hABCD_0000_0000_5555, 1'b1, 18'h15556);
    @(negedge clk);
    chk("t2_rsp_latency", 64'(bus.rdata_en_o[1]), 64'd1);

    // Predicated-off write on ch3: consumed, nothing issued.
    cyc();
    set_w(3, 6'd10, 16'hDEAD, 1'b0);
    @(negedge clk);
    chk("t3_w_rdy_pred0", 64'(bus.w_rdy_o[3]), 64'd1);
    cyc();
    clr_w(3);
    @(negedge clk);
    chk("t3_no_q_valid", 64'(bus.tcdm_q_valid_o[3]), 64'd0);
    chk("t3_idle_busy", 64'(bus.busy_o), 64'd0);

    // Read credit limit on ch2 with responses withheld and CGRA not ready.
    cyc();
    bus.rdata_rdy_i[2] = 1'b0;
    set_r(2, 6'd1);
    exp_q(2, 1'b0, 48'h1008, 64'h0, 8'h00);
    @(negedge clk);
    chk("t4_rd1_rdy", 64'(bus.raddr_rdy_o[2]), 64'd1);
    cyc();
    set_r(2, 6'd2);
    exp_q(2, 1'b0, 48'h1010, 64'h0, 8'h00);
    @(negedge clk);
    chk("t4_rd2_rdy", 64'(bus.raddr_rdy_o[2]), 64'd1);
    cyc();
    set_r(2, 6'd3);
    exp_q(2, 1'b0, 48'h1018, 64'h0, 8'h00);
    @(negedge clk);
    chk("t4_rd3_stall", 64'(bus.raddr_rdy_o[2]), 64'd0);
    repeat (3) cyc();
    @(negedge clk);
    chk("t4_rd3_still_stalled", 64'(bus.raddr_rdy_o[2]), 64'd0);
    pvalid(2, 64'hFFFF_0000_0000_0011, 1'b1, 18'h00046);
    @(negedge clk);
    chk("t4_rsp_pending", 64'(bus.rdata_en_o[2]), 64'd1);
    chk("t4_stall_until_pop", 64'(bus.raddr_rdy_o[2]), 64'd0);
    cyc();
    bus.rdata_rdy_i[2] = 1'b1;
    cyc();
    @(negedge clk);
    chk("t4_rd3_resumes", 64'(bus.raddr_rdy_o[2]), 64'd1);
    cyc();
    clr_r(2);
    @(negedge clk);
    pvalid(2, 64'h22, 1'b1, 18'h0008A);
    pvalid(2, 64'h33, 1'b1, 18'h000CE);

    // Stall counter on ch0: five cycles of valid without ready.
    cyc();
    bus.tcdm_q_ready_i[0] = 1'b0;
    set_w(0, 6'd0, 16'h0077, 1'b1);
    exp_q(0, 1'b1, 48'h1000, 64'h77, 8'hFF);
    @(negedge clk);
    chk("t5_w_rdy", 64'(bus.w_rdy_o[0]), 64'd1);
    cyc();
    clr_w(0);
    repeat (2) cyc();
    @(negedge clk);
    chk("t5_valid_held", 64'(bus.tcdm_q_valid_o[0]), 64'd1);
    repeat (3) cyc();
    bus.tcdm_q_ready_i[0] = 1'b1;
    @(negedge clk);
    chk("t5_addr_stable", 64'(bus.tcdm_q_addr_o[0 +: TAW]), 64'h1000);
    cyc();
    @(negedge clk);
    chk("t5_perf_stall", 64'(bus.perf_stall_o[31:0]), EXP_STALL);

    // Address wrap at the top of the TCDM space and the largest word address.
    cyc();
    bus.base_addr_i = 48'hFFFF_FFFF_FFF8;
    set_w(3, 6'd1, 16'hCAFE, 1'b1);
    exp_q(3, 1'b1, 48'h0, 64'hCAFE, 8'hFF);
    @(negedge clk);
    chk("t6_wrap_w_rdy", 64'(bus.w_rdy_o[3]), 64'd1);
    cyc();
    bus.base_addr_i = 48'h1000;
    set_w(3, 6'd63, 16'h0001, 1'b1);
    exp_q(3, 1'b1, 48'h11F8, 64'h1, 8'hFF);
    @(negedge clk);
    chk("t6_b2b_w_rdy", 64'(bus.w_rdy_o[3]), 64'd1);
    cyc();
    clr_w(3);

    // Reset with one read outstanding on ch1; the late response is dropped.
    cyc();
    set_r(1, 6'd9);
    exp_q(1, 1'b0, 48'h1048, 64'h0, 8'h00);
    @(negedge clk);
    chk("t7_raddr_rdy", 64'(bus.raddr_rdy_o[1]), 64'd1);
    cyc();
    clr_r(1);
    cyc();
    @(negedge clk);
    chk("t7_busy_outstanding", 64'(bus.busy_o), 64'd1);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    pvalid(1, 64'h99, 1'b0, '0);
    @(negedge clk);
    chk("t7_late_rsp_dropped", 64'(bus.rdata_en_o[1]), 64'd0);
    chk("t7_busy_cleared", 64'(bus.busy_o), 64'd0);

    repeat (3) cyc();
    chk("leftover_req", 64'(exp_req.size()), 64'd0);
    chk("leftover_rsp", 64'(exp_rsp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
